// File: rtl/cbd_sampler_pkg.sv
// rtl/cbd_sampler_pkg.sv - ML-KEM types, constants and CBD coefficient mapping
package cbd_sampler_pkg;

   localparam int ML_KEM_K = 3;
   localparam int ML_KEM_Q = 3329;
   localparam int ML_KEM_N = 256;

   typedef logic [ML_KEM_N-1:0][11:0] poly_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      DONE   = 2'd2
   } cbd_state_t;

   function automatic logic [1:0] popcnt3(input logic [2:0] v);
      return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
   endfunction

   // Unused high bits of a_bits/b_bits must be zero when ETA=2.
   function automatic logic [11:0] cbd_coeff(input logic [2:0] a_bits, input logic [2:0] b_bits);
      logic [1:0] a;
      logic [1:0] b;
      a = popcnt3(a_bits);
      b = popcnt3(b_bits);
      if (a >= b) begin
         return {10'd0, a - b};
      end
      return 12'(ML_KEM_Q) - {10'd0, b - a};
   endfunction

endpackage

// File: rtl/cbd_sampler_if.sv
// rtl/cbd_sampler_if.sv - PRF word stream into the CBD sampler
interface cbd_sampler_if #(
   parameter int W = 32
) ();

   logic [W-1:0] data_i;
   logic         valid_i;
   logic         ready_o;

   modport master (output data_i, output valid_i, input ready_o);
   modport slave  (input data_i, input valid_i, output ready_o);

endinterface

// File: rtl/cbd_sampler_gearbox.sv
// rtl/cbd_sampler_gearbox.sv - 2*W bit buffer turning W-bit words into 2*ETA-bit chunks
module cbd_sampler_gearbox #(
   parameter int W      = 32,
   parameter int ETA    = 2,
   parameter int NWORDS = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   input  logic            en_i,
   input  logic [W-1:0]    data_i,
   input  logic            valid_i,
   output logic            ready_o,
   output logic [2*ETA-1:0] bits_o,
   output logic            bits_valid_o
);

   localparam int CB = 2 * ETA;
   localparam int BW = 2 * W;
   localparam int FW = $clog2(BW + 1);
   localparam int CW = $clog2(NWORDS + 1);

   logic [BW-1:0] r_buf;
   logic [FW-1:0] r_fill;
   logic [CW-1:0] r_word_cnt;

   logic          w_accept;
   logic          w_consume;
   logic [BW-1:0] w_shifted;
   logic [FW-1:0] w_fill_after;

   // Only accept when the whole word fits; the word cap stops excess PRF output.
   assign ready_o      = en_i && (r_fill <= FW'(W)) && (r_word_cnt < CW'(NWORDS));
   assign w_accept     = ready_o && valid_i;
   assign w_consume    = en_i && (r_fill >= FW'(CB));
   assign bits_o       = r_buf[CB-1:0];
   assign bits_valid_o = w_consume;

   assign w_shifted    = w_consume ? (r_buf >> CB) : r_buf;
   assign w_fill_after = w_consume ? (r_fill - FW'(CB)) : r_fill;

   // Bits above fill are kept zero, so a new word can simply be OR-ed in.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_buf      <= '0;
         r_fill     <= '0;
         r_word_cnt <= '0;
      end else if (w_accept) begin
         r_buf      <= w_shifted | ({{W{1'b0}}, data_i} << w_fill_after);
         r_fill     <= w_fill_after + FW'(W);
         r_word_cnt <= r_word_cnt + CW'(1);
      end else begin
         r_buf      <= w_shifted;
         r_fill     <= w_fill_after;
      end
   end

endmodule

// File: rtl/cbd_sampler.sv
// rtl/cbd_sampler.sv - centered-binomial sampler filling one ML-KEM poly vector per run
module cbd_sampler
   import cbd_sampler_pkg::*;
#(
   parameter int ETA   = 2,
   parameter int NPOLY = ML_KEM_K,
   parameter int W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              run_i,
   cbd_sampler_if.slave      s_if,
   output poly_t [NPOLY-1:0] polyvec_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int NWORDS = NPOLY * ML_KEM_N * 2 * ETA / W;
   localparam int PW     = (NPOLY > 1) ? $clog2(NPOLY) : 1;

   cbd_state_t        r_state;
   cbd_state_t        w_next;
   logic [7:0]        r_coeff_cnt;
   logic [PW-1:0]     r_poly_cnt;
   poly_t [NPOLY-1:0] r_polyvec;

   logic              w_start;
   logic              w_last;
   logic              w_busy;
   logic              w_done;
   logic              w_bits_valid;
   logic [2*ETA-1:0]  w_bits;
   logic [11:0]       w_coeff;

   assign w_start = (r_state == IDLE) && run_i;
   assign w_last  = w_bits_valid && (r_coeff_cnt == 8'd255) && (r_poly_cnt == PW'(NPOLY - 1));

   cbd_sampler_gearbox #(
      .W      (W),
      .ETA    (ETA),
      .NWORDS (NWORDS)
   ) u_gearbox (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clr_i        (w_start),
      .en_i         (r_state == SAMPLE),
      .data_i       (s_if.data_i),
      .valid_i      (s_if.valid_i),
      .ready_o      (s_if.ready_o),
      .bits_o       (w_bits),
      .bits_valid_o (w_bits_valid)
   );

   assign w_coeff = cbd_coeff(3'(w_bits[ETA-1:0]), 3'(w_bits[2*ETA-1:ETA]));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (run_i) w_next = SAMPLE;
         end
         SAMPLE: begin
            w_busy = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Entries not yet written in this run keep their previous contents.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_coeff_cnt <= '0;
         r_poly_cnt  <= '0;
         r_polyvec   <= '0;
      end else if (w_start) begin
         r_coeff_cnt <= '0;
         r_poly_cnt  <= '0;
      end else if (w_bits_valid) begin
         r_polyvec[r_poly_cnt][r_coeff_cnt] <= w_coeff;
         r_coeff_cnt <= r_coeff_cnt + 8'd1;
         if (r_coeff_cnt == 8'd255) begin
            r_poly_cnt <= r_poly_cnt + PW'(1);
         end
      end
   end

   assign polyvec_o = r_polyvec;
   assign busy_o    = w_busy;
   assign done_o    = w_done;

endmodule

// File: tb/tb_cbd_sampler.sv
// tb/tb_cbd_sampler.sv - directed and model-checked bench for cbd_sampler
module tb_cbd_sampler;
   import cbd_sampler_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic run_a, run_b, run_c;
   logic [31:0] tb_data;
   logic tb_valid;
   poly_t [0:0] pv_a;
   poly_t [2:0] pv_b;
   poly_t [0:0] pv_c;
   logic busy_a, busy_b, busy_c;
   logic done_a, done_b, done_c;

   int total = 0;
   int bad = 0;
   logic [31:0] g_words [0:143];

   always #5 clk = ~clk;

   cbd_sampler_if #(.W(32)) if_a ();
   cbd_sampler_if #(.W(32)) if_b ();
   cbd_sampler_if #(.W(32)) if_c ();

   assign if_a.data_i = tb_data;
   assign if_b.data_i = tb_data;
   assign if_c.data_i = tb_data;
   assign if_a.valid_i = tb_valid;
   assign if_b.valid_i = tb_valid;
   assign if_c.valid_i = tb_valid;

   cbd_sampler #(.ETA(2), .NPOLY(1), .W(32)) u_a (
      .clk_i(clk), .rst_i(rst), .run_i(run_a), .s_if(if_a),
      .polyvec_o(pv_a), .busy_o(busy_a), .done_o(done_a));

   cbd_sampler #(.ETA(2), .NPOLY(3), .W(32)) u_b (
      .clk_i(clk), .rst_i(rst), .run_i(run_b), .s_if(if_b),
      .polyvec_o(pv_b), .busy_o(busy_b), .done_o(done_b));

   cbd_sampler #(.ETA(3), .NPOLY(1), .W(32)) u_c (
      .clk_i(clk), .rst_i(rst), .run_i(run_c), .s_if(if_c),
      .polyvec_o(pv_c), .busy_o(busy_c), .done_o(done_c));

   typedef struct {
      logic [31:0] word;
      int          coeff;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic get_ready(input int sel);
      case (sel)
         0: return if_a.ready_o;
         1: return if_b.ready_o;
         default: return if_c.ready_o;
      endcase
   endfunction

   function automatic logic get_done(input int sel);
      case (sel)
         0: return done_a;
         1: return done_b;
         default: return done_c;
      endcase
   endfunction

   task automatic set_run(input int sel, input logic v);
      run_a = (sel == 0) ? v : 1'b0;
      run_b = (sel == 1) ? v : 1'b0;
      run_c = (sel == 2) ? v : 1'b0;
   endtask

   // Reference: coefficient n reads stream bits 2*eta*n .. 2*eta*n+2*eta-1, LSB-first.
   function automatic int model_coeff(input int eta, input int n);
      int a = 0;
      int b = 0;
      int k0;
      int k1;
      for (int k = 0; k < eta; k++) begin
         k0 = 2 * eta * n + k;
         k1 = k0 + eta;
         a += int'(g_words[k0 / 32][k0 % 32]);
         b += int'(g_words[k1 / 32][k1 % 32]);
      end
      return (a >= b) ? (a - b) : (3329 + a - b);
   endfunction

   task automatic run_feed(input int sel, input int nwords, input bit gaps, input int rerun_at,
                           output int acc, output int dones, output bit late_ready, output bit tmo);
      int idx = 0;
      int cyc = 0;
      int post = -1;
      acc = 0;
      dones = 0;
      late_ready = 1'b0;
      tmo = 1'b0;
      tb_valid = 1'b0;
      @(negedge clk);
      set_run(sel, 1'b1);
      @(negedge clk);
      while (post != 0) begin
         set_run(sel, (cyc == rerun_at) ? 1'b1 : 1'b0);
         tb_valid = (idx >= nwords) ? 1'b1 : (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
         tb_data = (idx < nwords) ? g_words[idx] : 32'hDEAD_BEEF;
         if (get_done(sel)) begin
            dones++;
            if (post < 0) post = 4;
         end
         if (get_ready(sel) && idx >= nwords) late_ready = 1'b1;
         if (get_ready(sel) && tb_valid) begin
            acc++;
            idx++;
         end
         if (post > 0) post--;
         cyc++;
         if (cyc > 20000) begin
            tmo = 1'b1;
            post = 0;
         end
         @(negedge clk);
      end
      set_run(sel, 1'b0);
      tb_valid = 1'b0;
   endtask

   task automatic check_run(input string name, input int nw, input int acc, input int dones,
                            input bit late_ready, input bit tmo);
      chk({name, "_timeout"}, int'(tmo), 0);
      chk({name, "_accepted"}, acc, nw);
      chk({name, "_done_pulses"}, dones, 1);
      chk({name, "_ready_after_last"}, int'(late_ready), 0);
   endtask

   task automatic check_uniform_a(input string name, input int exp);
      int got = exp;
      for (int j = 0; j < 256; j++) begin
         if (int'(pv_a[0][j]) != exp && got == exp) got = int'(pv_a[0][j]);
      end
      chk(name, got, exp);
   endtask

   task automatic check_model_b(input string name);
      int nbad = 0;
      for (int p = 0; p < 3; p++) begin
         for (int j = 0; j < 256; j++) begin
            if (int'(pv_b[p][j]) != model_coeff(2, p * 256 + j)) nbad++;
         end
      end
      chk(name, nbad, 0);
   endtask

   task automatic check_model_c(input string name);
      int nbad = 0;
      for (int j = 0; j < 256; j++) begin
         if (int'(pv_c[0][j]) != model_coeff(3, j)) nbad++;
      end
      chk(name, nbad, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [9];
      int acc, dones, cnt, nz;
      bit late, tmo;

      vecs[0] = '{32'h0000_0000, 0};
      vecs[1] = '{32'h3333_3333, 2};
      vecs[2] = '{32'hCCCC_CCCC, 3327};
      vecs[3] = '{32'hFFFF_FFFF, 0};
      vecs[4] = '{32'h1111_1111, 1};
      vecs[5] = '{32'h4444_4444, 3328};
      vecs[6] = '{32'h6666_6666, 0};
      vecs[7] = '{32'h7777_7777, 1};
      vecs[8] = '{32'h8888_8888, 3328};

      rst = 1'b1;
      set_run(0, 1'b0);
      tb_valid = 1'b0;
      tb_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ready", int'(get_ready(0)), 0);
      chk("reset_busy", int'(busy_a), 0);
      chk("reset_done", int'(done_a), 0);
      chk("reset_polyvec_zero", int'(pv_a == '0), 1);

      for (int i = 0; i < 9; i++) begin
         for (int w = 0; w < 32; w++) g_words[w] = vecs[i].word;
         run_feed(0, 32, 1'b0, -1, acc, dones, late, tmo);
         check_run($sformatf("T2_vec%0d", i), 32, acc, dones, late, tmo);
         check_uniform_a($sformatf("T2_vec%0d_coeff", i), vecs[i].coeff);
         chk($sformatf("T2_vec%0d_idle", i), int'(busy_a), 0);
      end

      for (int w = 0; w < 96; w++) g_words[w] = $urandom;
      run_feed(1, 96, 1'b1, -1, acc, dones, late, tmo);
      check_run("T3", 96, acc, dones, late, tmo);
      check_model_b("T3_coeff_mismatches");

      for (int w = 0; w < 96; w++) g_words[w] = $urandom;
      run_feed(1, 96, 1'b0, 100, acc, dones, late, tmo);
      check_run("T5", 96, acc, dones, late, tmo);
      check_model_b("T5_coeff_mismatches");

      for (int w = 0; w < 48; w++) g_words[w] = 32'h0;
      g_words[0] = 32'hC000_0000;
      run_feed(2, 48, 1'b0, -1, acc, dones, late, tmo);
      check_run("T4a", 48, acc, dones, late, tmo);
      chk("T4a_coeff5", int'(pv_c[0][5]), 2);
      nz = 0;
      for (int j = 0; j < 256; j++) if (j != 5 && pv_c[0][j] != 12'd0) nz++;
      chk("T4a_others_nonzero", nz, 0);

      g_words[0] = 32'h0000_0007;
      run_feed(2, 48, 1'b0, -1, acc, dones, late, tmo);
      chk("T4b_coeff0", int'(pv_c[0][0]), 3);
      nz = 0;
      for (int j = 1; j < 256; j++) if (pv_c[0][j] != 12'd0) nz++;
      chk("T4b_others_nonzero", nz, 0);

      for (int w = 0; w < 48; w++) g_words[w] = $urandom;
      run_feed(2, 48, 1'b1, -1, acc, dones, late, tmo);
      check_run("T4c", 48, acc, dones, late, tmo);
      check_model_c("T4c_coeff_mismatches");

      for (int w = 0; w < 32; w++) g_words[w] = 32'h3333_3333;
      cnt = 0;
      acc = 0;
      @(negedge clk);
      set_run(0, 1'b1);
      @(negedge clk);
      set_run(0, 1'b0);
      tb_data = 32'h3333_3333;
      tb_valid = 1'b1;
      while (acc < 10 && cnt < 200) begin
         if (get_ready(0)) acc++;
         @(negedge clk);
         cnt++;
      end
      tb_valid = 1'b0;
      chk("T6_words_before_reset", acc, 10);
      chk("T6_busy_before_reset", int'(busy_a), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("T6_busy_after_reset", int'(busy_a), 0);
      chk("T6_ready_after_reset", int'(get_ready(0)), 0);
      chk("T6_polyvec_zero", int'(pv_a == '0), 1);
      run_feed(0, 32, 1'b0, -1, acc, dones, late, tmo);
      check_run("T6_rerun", 32, acc, dones, late, tmo);
      check_uniform_a("T6_rerun_coeff", 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
